// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front-end for the 4-bit ALU.
// It accepts one command at a time and drives the ALU operands.
// After SETTLE_CYCLES edges it captures the ALU result and returns it as a response.
// A modulo by zero never samples the ALU: its zero result is reported one edge after accept,
// whatever SETTLE_CYCLES is set to.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [3:0]           cmdA,
  input  logic [3:0]           cmdB,
  input  logic [1:0]           cmdOp,
  output logic [3:0]           aInt,
  output logic [3:0]           bInt,
  output logic [1:0]           opCode,
  input  logic [7:0]           intResult,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [7:0]           rspResult,
  output logic [1:0]           rspOp,
  output logic                 rspDivZero,
  output logic [CNT_WIDTH-1:0] opCount
);

  // The settle counter is 4 bits wide, so the legal range stops at 15.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_bad_settle
    $error("alu_cmd_sequencer: SETTLE_CYCLES must be in 1..15");
  end
  if (CNT_WIDTH < 1) begin : gen_bad_cnt
    $error("alu_cmd_sequencer: CNT_WIDTH must be at least 1");
  end

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e     state;
  logic [3:0] settleCnt;
  logic       pendDivZero;
  logic       cmdDivZero;

  // Modulo with a zero divisor is answered without sampling the ALU.
  assign cmdDivZero = (cmdOp == 2'b10) && (cmdB == 4'd0);

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= StIdle;
      cmdReady    <= 1'b0;
      rspValid    <= 1'b0;
      rspDivZero  <= 1'b0;
      aInt        <= 4'd0;
      bInt        <= 4'd0;
      opCode      <= 2'd0;
      rspResult   <= 8'd0;
      rspOp       <= 2'd0;
      opCount     <= '0;
      settleCnt   <= 4'd0;
      pendDivZero <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (cmdValid && cmdReady) begin
            aInt        <= cmdA;
            bInt        <= cmdB;
            opCode      <= cmdOp;
            rspOp       <= cmdOp;
            cmdReady    <= 1'b0;
            pendDivZero <= cmdDivZero;
            settleCnt   <= cmdDivZero ? 4'd1 : SettleInit;
            state       <= StDrive;
          end else begin
            // The first edge out of reset only raises ready; there is no accept on that edge.
            cmdReady <= 1'b1;
          end
        end
        StDrive: begin
          if (settleCnt == 4'd1) begin
            rspResult  <= pendDivZero ? 8'h00 : intResult;
            rspDivZero <= pendDivZero;
            rspValid   <= 1'b1;
            state      <= StResp;
          end else begin
            settleCnt <= settleCnt - 4'd1;
          end
        end
        StResp: begin
          if (rspValid && rspReady) begin
            rspValid <= 1'b0;
            opCount  <= opCount + CNT_WIDTH'(1);
            cmdReady <= 1'b1;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer.
// Three instances are built: settle 1 with an 8-bit count, settle 3 with an 8-bit count,
// and settle 4 with a 2-bit count.
// A transaction-level model tracks each instance, and every cycle all outputs are compared
// against it. Directed literal checks pin the model at the key points.
module tb_alu_cmd_sequencer;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] resetN, cmdValid, rspReady, cmdReady, rspValid, rspDivZero;
  logic [3:0]    cmdA[NI], cmdB[NI], aInt[NI], bInt[NI];
  logic [1:0]    cmdOp[NI], opCode[NI], rspOp[NI];
  logic [7:0]    intResult[NI], rspResult[NI], opCount[NI];

  function automatic logic [7:0] aluRef(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    case (op)
      2'd0:    return 8'(a) + 8'(b);
      2'd1:    return 8'(a) * 8'(b);
      2'd2:    return (b == 4'd0) ? 8'h00 : 8'(a % b);
      default: return {4'h0, a & b};
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int unsigned S  = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int unsigned CW = (g == 2) ? 2 : 8;
    logic [CW-1:0] cnt;
    alu_cmd_sequencer #(.SETTLE_CYCLES(S), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .resetN    (resetN[g]),
      .cmdValid  (cmdValid[g]),
      .cmdReady  (cmdReady[g]),
      .cmdA      (cmdA[g]),
      .cmdB      (cmdB[g]),
      .cmdOp     (cmdOp[g]),
      .aInt      (aInt[g]),
      .bInt      (bInt[g]),
      .opCode    (opCode[g]),
      .intResult (intResult[g]),
      .rspValid  (rspValid[g]),
      .rspReady  (rspReady[g]),
      .rspResult (rspResult[g]),
      .rspOp     (rspOp[g]),
      .rspDivZero(rspDivZero[g]),
      .opCount   (cnt)
    );
    assign opCount[g]   = 8'(cnt);
    assign intResult[g] = aluRef(aInt[g], bInt[g], opCode[g]);
  end

  // Model state: one transaction in flight per instance, with the response due at cycle mAt.
  bit         mReady[NI], mValid[NI], mDz[NI], mBusy[NI], mPend[NI];
  logic [3:0] mA[NI], mB[NI];
  logic [1:0] mOp[NI];
  logic [7:0] mRes[NI], mCnt[NI];
  int         mAt[NI];
  int         cyc = 0;
  int         nCmp = 0;
  int         nBad = 0;
  bit         cmpEn = 1'b0;

  function automatic int settleOf(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  function automatic logic [7:0] cntMask(int i);
    return (i == 2) ? 8'h03 : 8'hFF;
  endfunction

  task automatic modelStep(int i);
    if (!resetN[i]) begin
      mReady[i] = 0; mValid[i] = 0; mDz[i] = 0; mBusy[i] = 0; mPend[i] = 0;
      mA[i] = 4'd0; mB[i] = 4'd0; mOp[i] = 2'd0; mRes[i] = 8'd0; mCnt[i] = 8'd0;
    end else if (mValid[i]) begin
      if (rspReady[i]) begin
        mValid[i] = 0;
        mBusy[i]  = 0;
        mReady[i] = 1;
        mCnt[i]   = (mCnt[i] + 8'd1) & cntMask(i);
      end
    end else if (!mBusy[i]) begin
      if (mReady[i] && cmdValid[i]) begin
        mA[i]     = cmdA[i];
        mB[i]     = cmdB[i];
        mOp[i]    = cmdOp[i];
        mReady[i] = 0;
        mBusy[i]  = 1;
        mPend[i]  = (cmdOp[i] == 2'd2) && (cmdB[i] == 4'd0);
        mAt[i]    = cyc + (mPend[i] ? 1 : settleOf(i));
      end else begin
        mReady[i] = 1;
      end
    end else if (cyc == mAt[i]) begin
      mValid[i] = 1;
      mDz[i]    = mPend[i];
      mRes[i]   = mPend[i] ? 8'h00 : aluRef(mA[i], mB[i], mOp[i]);
    end
  endtask

  task automatic compareAll();
    logic [30:0] expV, actV;
    if (cmpEn) begin
      for (int i = 0; i < NI; i++) begin
        expV = {mReady[i], mValid[i], mDz[i], mA[i], mB[i], mOp[i], mRes[i], mOp[i], mCnt[i]};
        actV = {cmdReady[i], rspValid[i], rspDivZero[i], aInt[i], bInt[i], opCode[i],
                rspResult[i], rspOp[i], opCount[i]};
        nCmp++;
        if (actV !== expV) begin
          nBad++;
          $display("FAIL outputs inst%0d cyc %0d: got %h expected %h", i, cyc, actV, expV);
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, step the model on the rising edge, settle 2 time units.
  task automatic tick();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) modelStep(i);
    #2;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(int i, logic [3:0] a, logic [3:0] b, logic [1:0] op);
    bit done;
    done = 0;
    cmdA[i] = a; cmdB[i] = b; cmdOp[i] = op; cmdValid[i] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (mReady[i]) done = 1;
      tick();
    end
    cmdValid[i] = 1'b0;
    if (!done) begin
      nBad++;
      $display("FAIL issue timeout inst%0d", i);
    end
  endtask

  task automatic waitValid(int i);
    for (int k = 0; k < 40 && !mValid[i]; k++) tick();
    if (!mValid[i]) begin
      nBad++;
      $display("FAIL waitValid timeout inst%0d", i);
    end
  endtask

  initial begin
    logic [7:0] cntExp [5];
    cntExp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    resetN = '0; cmdValid = '0; rspReady = '1;
    for (int i = 0; i < NI; i++) begin
      cmdA[i] = 4'd0; cmdB[i] = 4'd0; cmdOp[i] = 2'd0;
    end
    tick();
    cmpEn = 1'b1;
    tick();
    check("reset cmdReady", 32'(cmdReady[0]), 32'd0);
    check("reset rspValid", 32'(rspValid[0]), 32'd0);
    check("reset opCount", 32'(opCount[0]), 32'd0);
    check("reset aInt", 32'(aInt[0]), 32'd0);
    resetN = '1;
    tick();
    check("ready after reset", 32'(cmdReady[0]), 32'd1);

    // Add with settle 1.
    issue(0, 4'd9, 4'd7, 2'd0);
    check("add aInt", 32'(aInt[0]), 32'd9);
    check("add bInt", 32'(bInt[0]), 32'd7);
    check("add valid E0", 32'(rspValid[0]), 32'd0);
    tick();
    check("add valid E1", 32'(rspValid[0]), 32'd1);
    check("add result", 32'(rspResult[0]), 32'h10);
    tick();
    check("add opCount", 32'(opCount[0]), 32'd1);
    check("add ready again", 32'(cmdReady[0]), 32'd1);

    // Multiply with settle 3.
    issue(1, 4'd15, 4'd15, 2'd1);
    check("mul valid E0", 32'(rspValid[1]), 32'd0);
    tick();
    check("mul valid E1", 32'(rspValid[1]), 32'd0);
    tick();
    check("mul valid E2", 32'(rspValid[1]), 32'd0);
    tick();
    check("mul valid E3", 32'(rspValid[1]), 32'd1);
    check("mul result", 32'(rspResult[1]), 32'hE1);
    check("mul divzero", 32'(rspDivZero[1]), 32'd0);
    tick();

    // Modulo by zero responds after one edge, even with settle 3.
    issue(1, 4'd13, 4'd0, 2'd2);
    tick();
    check("modz valid", 32'(rspValid[1]), 32'd1);
    check("modz result", 32'(rspResult[1]), 32'h00);
    check("modz divzero", 32'(rspDivZero[1]), 32'd1);
    tick();
    issue(1, 4'd13, 4'd5, 2'd2);
    tick(); tick(); tick();
    check("mod result", 32'(rspResult[1]), 32'h03);
    check("mod divzero", 32'(rspDivZero[1]), 32'd0);
    tick();

    // Response stall while a second command waits.
    rspReady[1] = 1'b0;
    issue(1, 4'hC, 4'hA, 2'd3);
    cmdA[1] = 4'd3; cmdB[1] = 4'd4; cmdOp[1] = 2'd0; cmdValid[1] = 1'b1;
    tick(); tick(); tick();
    check("and valid", 32'(rspValid[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall result", 32'(rspResult[1]), 32'h08);
      check("stall rspOp", 32'(rspOp[1]), 32'd3);
      check("stall cmdReady", 32'(cmdReady[1]), 32'd0);
    end
    rspReady[1] = 1'b1;
    tick();
    check("post-stall ready", 32'(cmdReady[1]), 32'd1);
    check("no accept on handshake", 32'(aInt[1]), 32'hC);
    check("stall opCount", 32'(opCount[1]), 32'd4);
    tick();
    cmdValid[1] = 1'b0;
    check("second accepted", 32'(aInt[1]), 32'd3);
    tick(); tick(); tick(); tick();
    check("second opCount", 32'(opCount[1]), 32'd5);

    // Reset mid-operation with settle 4.
    issue(2, 4'd1, 4'd2, 2'd0);
    waitValid(2);
    tick();
    check("pre-reset opCount", 32'(opCount[2]), 32'd1);
    issue(2, 4'd2, 4'd3, 2'd1);
    tick();
    resetN[2] = 1'b0;
    tick();
    check("midreset rspValid", 32'(rspValid[2]), 32'd0);
    check("midreset aInt", 32'(aInt[2]), 32'd0);
    check("midreset bInt", 32'(bInt[2]), 32'd0);
    check("midreset opCode", 32'(opCode[2]), 32'd0);
    check("midreset opCount", 32'(opCount[2]), 32'd0);
    resetN[2] = 1'b1;
    tick();
    check("ready after midreset", 32'(cmdReady[2]), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    check("no stray response", 32'(rspValid[2]), 32'd0);

    // A 2-bit counter wraps.
    for (int k = 0; k < 5; k++) begin
      issue(2, 4'(k + 1), 4'(k + 2), 2'(k));
      waitValid(2);
      tick();
      check("wrap opCount", 32'(opCount[2]), 32'(cntExp[k]));
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
